ysyx_22041071_dmem_resp: RTL and testbench

//  Data-memory responder: the slave end of the MEM-stage load/store port. Accepts one
//  64-bit word request (read or byte-masked write) per valid/ready handshake and returns
//  one response per request after a fixed wait. Replaces the DPI RAM model for

---
 rtl/ysyx_22041071_dmem_resp_pkg.sv | 24 ++
 rtl/ysyx_22041071_dmem_resp_if.sv | 33 +++
 rtl/ysyx_22041071_dmem_array.sv | 47 ++++
 rtl/ysyx_22041071_dmem_resp.sv | 116 +++++++++++
 tb/tb_ysyx_22041071_dmem_resp.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22041071_dmem_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22041071_dmem_resp_pkg
// Description : Shared widths, default base address and responder FSM
//               encoding for the MEM-stage data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_22041071_dmem_resp_pkg;

  localparam int ADDR_BUS = 64;
  localparam int DATA_BUS = 64;
  localparam int MASK_BUS = DATA_BUS / 8;

  localparam logic [ADDR_BUS-1:0] BASE_ADDR_DEFAULT = 64'h0000_0000_8000_0000;

  // Responder FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

endpackage
`default_nettype wire

// File: rtl/ysyx_22041071_dmem_resp_if.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22041071_dmem_resp_if
// Description : Load/store request + response channel between the MEM stage
//               (master) and the data-memory responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface ysyx_22041071_dmem_resp_if;
  import ysyx_22041071_dmem_resp_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [ADDR_BUS-1:0] req_addr;
  logic [DATA_BUS-1:0] req_wdata;
  logic [MASK_BUS-1:0] req_wmask;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DATA_BUS-1:0] rsp_rdata;
  logic                rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface
`default_nettype wire

// File: rtl/ysyx_22041071_dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22041071_dmem_array
// Description : 1R1W synchronous SRAM, 2**DEPTH_LOG2 x 64 bit, byte-lane
//               write mask, read-before-write on a shared address.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22041071_dmem_array
  import ysyx_22041071_dmem_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  wire logic                  clk,
  input  wire logic                  we,
  input  wire logic                  re,
  input  wire logic [DEPTH_LOG2-1:0] addr,
  input  wire logic [MASK_BUS-1:0]   wmask,
  input  wire logic [DATA_BUS-1:0]   wdata,
  output logic      [DATA_BUS-1:0]   rdata
);

  logic [DATA_BUS-1:0] mem [2**DEPTH_LOG2];
  logic [DATA_BUS-1:0] rdata_q;

  // Read port: the output register only moves on a read, so the word is held
  // for as long as the caller needs it.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem[addr];
    end
  end

  // Write port: per-lane enables; the read above sees the pre-write word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < MASK_BUS; i++) begin
        if (wmask[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/ysyx_22041071_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22041071_dmem_resp
// Description : Data-memory responder for the MEM-stage load/store port.
//               Range check, accept/wait/respond FSM, response register and
//               the backing SRAM array.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22041071_dmem_resp
  import ysyx_22041071_dmem_resp_pkg::*;
#(
  parameter logic [ADDR_BUS-1:0] BASE_ADDR  = BASE_ADDR_DEFAULT,
  parameter int                  DEPTH_LOG2 = 12,
  parameter int                  LATENCY    = 1
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  ysyx_22041071_dmem_resp_if.slave  bus
);

  localparam logic [3:0] C_WAIT_INIT = 4'(LATENCY - 1);

  logic [ADDR_BUS-1:0]   offset;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] index;
  logic                  accept;
  logic                  arr_we;
  logic                  arr_re;
  logic [DATA_BUS-1:0]   arr_rdata;
  logic                  unused_offset_lo;

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic        valid_q, valid_d;
  logic        err_q,   err_d;
  logic        load_q,  load_d;

  // Window decode: below-base addresses fail the compare, above-window ones
  // leave bits set above the index field of the offset.
  assign offset           = bus.req_addr - BASE_ADDR;
  assign in_range         = (bus.req_addr >= BASE_ADDR) &&
                            (offset[ADDR_BUS-1:DEPTH_LOG2+3] == '0);
  assign index            = offset[DEPTH_LOG2+2:3];
  assign unused_offset_lo = ^offset[2:0];

  assign bus.req_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && bus.rsp_ready);
  assign accept        = bus.req_valid && bus.req_ready;
  assign arr_we        = accept && in_range && bus.req_we;
  assign arr_re        = accept && in_range && !bus.req_we;

  ysyx_22041071_dmem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (index),
    .wmask (bus.req_wmask),
    .wdata (bus.req_wdata),
    .rdata (arr_rdata)
  );

  // Next-state: count down in WAIT, retire in RESP, and let a same-cycle
  // accept override so back-to-back requests need no idle bubble.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    load_d  = load_q;
    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: ;
    endcase
    if (accept) begin
      state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
      cnt_d   = C_WAIT_INIT;
      err_d   = !in_range;
      load_d  = in_range && !bus.req_we;
    end
    valid_d = (state_d == ST_RESP);
  end

  // State and response registers; reset drops any pending response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      load_q  <= load_d;
    end
  end

  // Stores and errors return zero data; loads return the captured word.
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_err   = err_q;
  assign bus.rsp_rdata = load_q ? arr_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22041071_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22041071_dmem_resp
// Description : Self-checking bench for the data-memory responder, with a
//               LATENCY=1 instance and a LATENCY=3 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22041071_dmem_resp;

  logic clk;
  logic reset;

  int n_cmp;
  int n_bad;

  ysyx_22041071_dmem_resp_if bus1 ();
  ysyx_22041071_dmem_resp_if bus3 ();

  ysyx_22041071_dmem_resp #(
    .BASE_ADDR  (64'h0000_0000_8000_0000),
    .DEPTH_LOG2 (12),
    .LATENCY    (1)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  ysyx_22041071_dmem_resp #(
    .BASE_ADDR  (64'h0000_0000_8000_0000),
    .DEPTH_LOG2 (12),
    .LATENCY    (3)
  ) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  logic [63:0] sb [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One LATENCY=1 transaction on bus1 with the response taken immediately.
  task automatic txn1(input int id, input logic we, input logic [63:0] addr,
                      input logic [63:0] wd, input logic [7:0] m,
                      input logic [63:0] exp_rd, input logic exp_err);
    @(negedge clk);
    bus1.req_valid = 1'b1;
    bus1.req_we    = we;
    bus1.req_addr  = addr;
    bus1.req_wdata = wd;
    bus1.req_wmask = m;
    bus1.rsp_ready = 1'b1;
    #1;
    chk($sformatf("v%0d_req_ready", id), {63'd0, bus1.req_ready}, 64'd1);
    @(posedge clk);
    #1;
    bus1.req_valid = 1'b0;
    chk($sformatf("v%0d_rsp_valid", id), {63'd0, bus1.rsp_valid}, 64'd1);
    chk($sformatf("v%0d_rdata", id), bus1.rsp_rdata, exp_rd);
    chk($sformatf("v%0d_err", id), {63'd0, bus1.rsp_err}, {63'd0, exp_err});
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_drained", id), {63'd0, bus1.rsp_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;

    //        we    addr                    wdata                   mask   exp_rdata               err
    vecs[0]  = '{1'b1, 64'h0000_0000_8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 64'h0,                  1'b0};
    vecs[1]  = '{1'b0, 64'h0000_0000_8000_0010, 64'h0,                  8'h00, 64'h1122_3344_5566_7788, 1'b0};
    vecs[2]  = '{1'b1, 64'h0000_0000_8000_0008, 64'h0,                  8'hFF, 64'h0,                  1'b0};
    vecs[3]  = '{1'b1, 64'h0000_0000_8000_0008, 64'h0000_0000_00AB_0000, 8'h04, 64'h0,                  1'b0};
    vecs[4]  = '{1'b0, 64'h0000_0000_8000_0008, 64'h0,                  8'h00, 64'h0000_0000_00AB_0000, 1'b0};
    vecs[5]  = '{1'b1, 64'h0000_0000_8000_0000, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 64'h0,                  1'b0};
    vecs[6]  = '{1'b0, 64'h0000_0000_7FFF_FFF8, 64'h0,                  8'h00, 64'h0,                  1'b1};
    vecs[7]  = '{1'b0, 64'h0000_0000_8000_8000, 64'h0,                  8'h00, 64'h0,                  1'b1};
    vecs[8]  = '{1'b1, 64'h0000_0000_8000_8000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0,                  1'b1};
    vecs[9]  = '{1'b0, 64'h0000_0000_8000_0000, 64'h0,                  8'h00, 64'hDEAD_BEEF_CAFE_F00D, 1'b0};
    vecs[10] = '{1'b1, 64'h0000_0000_8000_7FF8, 64'h0,                  8'hFF, 64'h0,                  1'b0};
    vecs[11] = '{1'b1, 64'h0000_0000_8000_7FF8, 64'hA5A5_A5A5_5A5A_5A5A, 8'hF0, 64'h0,                  1'b0};
    vecs[12] = '{1'b0, 64'h0000_0000_8000_7FF8, 64'h0,                  8'h00, 64'hA5A5_A5A5_0000_0000, 1'b0};
    vecs[13] = '{1'b1, 64'h0000_0000_8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'h0,                  1'b0};
    vecs[14] = '{1'b0, 64'h0000_0000_8000_0013, 64'h0,                  8'h00, 64'h1122_3344_5566_7788, 1'b0};
    vecs[15] = '{1'b0, 64'hFFFF_FFFF_8000_0000, 64'h0,                  8'h00, 64'h0,                  1'b1};
    vecs[16] = '{1'b0, 64'h0000_0000_8000_0000, 64'h0,                  8'h00, 64'hDEAD_BEEF_CAFE_F00D, 1'b0};

    for (int k = 0; k < 16; k++) begin
      sb[k] = 64'h0F0F_0000_0000_0000 ^ (64'(k) * 64'h9E37_79B9_7F4A_7C15);
    end

    reset          = 1'b1;
    bus1.req_valid = 1'b0;
    bus1.req_we    = 1'b0;
    bus1.req_addr  = '0;
    bus1.req_wdata = '0;
    bus1.req_wmask = '0;
    bus1.rsp_ready = 1'b0;
    bus3.req_valid = 1'b0;
    bus3.req_we    = 1'b0;
    bus3.req_addr  = '0;
    bus3.req_wdata = '0;
    bus3.req_wmask = '0;
    bus3.rsp_ready = 1'b0;

    // Reset state
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid1", {63'd0, bus1.rsp_valid}, 64'd0);
    chk("rst_req_ready1", {63'd0, bus1.req_ready}, 64'd1);
    chk("rst_err1",       {63'd0, bus1.rsp_err},   64'd0);
    chk("rst_rdata1",     bus1.rsp_rdata,           64'd0);
    chk("rst_rsp_valid3", {63'd0, bus3.rsp_valid}, 64'd0);
    chk("rst_req_ready3", {63'd0, bus3.req_ready}, 64'd1);
    @(negedge clk);
    reset = 1'b1;

    // Directed vector table on the LATENCY=1 instance
    for (int i = 0; i < NVEC; i++) begin
      txn1(i, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wmask,
           vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // Asynchronous reset while a response is pending
    @(negedge clk);
    bus1.req_valid = 1'b1;
    bus1.req_we    = 1'b0;
    bus1.req_addr  = 64'h0000_0000_8000_0010;
    bus1.rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    bus1.req_valid = 1'b0;
    chk("mid_rsp_valid", {63'd0, bus1.rsp_valid}, 64'd1);
    chk("mid_req_ready", {63'd0, bus1.req_ready}, 64'd0);
    #1 reset = 1'b0;
    #1;
    chk("arst_rsp_valid", {63'd0, bus1.rsp_valid}, 64'd0);
    chk("arst_req_ready", {63'd0, bus1.req_ready}, 64'd1);
    chk("arst_rdata",     bus1.rsp_rdata,           64'd0);
    @(negedge clk);
    reset = 1'b1;
    txn1(100, 1'b0, 64'h0000_0000_8000_0010, 64'h0, 8'h00, 64'h1122_3344_5566_7788, 1'b0);

    // Backpressure on the LATENCY=3 instance
    @(negedge clk);
    bus3.req_valid = 1'b1;
    bus3.req_we    = 1'b1;
    bus3.req_addr  = 64'h0000_0000_8000_0020;
    bus3.req_wdata = 64'h0123_4567_89AB_CDEF;
    bus3.req_wmask = 8'hFF;
    bus3.rsp_ready = 1'b0;
    #1;
    chk("bp_ready_idle", {63'd0, bus3.req_ready}, 64'd1);
    @(posedge clk);
    #1;
    bus3.req_valid = 1'b0;
    chk("bp_lat_e0", {63'd0, bus3.rsp_valid}, 64'd0);
    @(posedge clk);
    #1;
    chk("bp_lat_e1", {63'd0, bus3.rsp_valid}, 64'd0);
    @(posedge clk);
    #1;
    chk("bp_lat_e2", {63'd0, bus3.rsp_valid}, 64'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus3.req_valid = 1'b1;
      bus3.req_we    = 1'b1;
      bus3.req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      chk($sformatf("bp_hold%0d_req_ready", c), {63'd0, bus3.req_ready}, 64'd0);
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold%0d_valid", c), {63'd0, bus3.rsp_valid}, 64'd1);
      chk($sformatf("bp_hold%0d_err", c),   {63'd0, bus3.rsp_err},   64'd0);
      chk($sformatf("bp_hold%0d_rdata", c), bus3.rsp_rdata,           64'd0);
    end
    @(negedge clk);
    bus3.req_we    = 1'b0;
    bus3.req_addr  = 64'h0000_0000_8000_0020;
    bus3.rsp_ready = 1'b1;
    #1;
    chk("bp_both_req_ready", {63'd0, bus3.req_ready}, 64'd1);
    @(posedge clk);
    #1;
    bus3.req_valid = 1'b0;
    chk("bp_after_hs", {63'd0, bus3.rsp_valid}, 64'd0);
    @(posedge clk);
    #1;
    chk("bp_load_e1", {63'd0, bus3.rsp_valid}, 64'd0);
    @(posedge clk);
    #1;
    chk("bp_load_valid", {63'd0, bus3.rsp_valid}, 64'd1);
    chk("bp_load_rdata", bus3.rsp_rdata, 64'h0123_4567_89AB_CDEF);
    chk("bp_load_err",   {63'd0, bus3.rsp_err}, 64'd0);
    @(posedge clk);
    #1;
    chk("bp_load_drained", {63'd0, bus3.rsp_valid}, 64'd0);

    // Streaming: 16 stores then 16 loads, one handshake per cycle
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      bus1.req_valid = 1'b1;
      bus1.req_we    = (k < 16);
      bus1.req_addr  = 64'h0000_0000_8000_0100 + 64'(8 * (k % 16));
      bus1.req_wdata = sb[k % 16];
      bus1.req_wmask = 8'hFF;
      bus1.rsp_ready = 1'b1;
      #1;
      chk($sformatf("st%0d_req_ready", k), {63'd0, bus1.req_ready}, 64'd1);
      @(posedge clk);
      #1;
      chk($sformatf("st%0d_rsp_valid", k), {63'd0, bus1.rsp_valid}, 64'd1);
      chk($sformatf("st%0d_err", k),       {63'd0, bus1.rsp_err},   64'd0);
      chk($sformatf("st%0d_rdata", k), bus1.rsp_rdata, (k < 16) ? 64'd0 : sb[k % 16]);
    end
    @(negedge clk);
    bus1.req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("st_drained", {63'd0, bus1.rsp_valid}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
